frame_buffer_arbiter: RTL and testbench

- Owns the double-buffered frame memory: two 320x240 buffers of 24-bit pixels, one physical memory port.
- Shares that single port between two requesters. The display path reads the front buffer; the draw path writes the back buffer.
- Sequences buffer swaps: a swap requested by the renderer takes effect only at a display frame boundary, so scanout never tears.

---
 rtl/frame_buffer_arbiter.sv | 72 +++++++
 tb/tb_frame_buffer_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one memory port between display reads and draw writes, with tear-free swaps at frame boundaries
module frame_buffer_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 24,
   parameter int FB_WORDS   = 76800,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disp_re,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              draw_we,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic [DATA_W-1:0] draw_wdata,
   output logic              draw_gnt,
   input  logic              swap_req,
   input  logic              frame_done,
   output logic              front_sel,
   output logic              swap_pending,
   output logic              swap_done,
   output logic              oob_err,
   output logic [ADDR_W:0]   mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] FB_LIM = FB_WORDS[ADDR_W-1:0];
   typedef enum logic {IDLE, PEND} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] starve_cnt;
   logic rd_oob, disp_oob, draw_oob, toggle;
   assign disp_oob  = disp_addr >= FB_LIM;
   assign draw_oob  = draw_addr >= FB_LIM;
   assign draw_gnt  = draw_we && (!disp_re || starve_cnt == SMAX);
   assign disp_gnt  = disp_re && !draw_gnt;
   assign mem_re    = disp_gnt && !disp_oob;
   assign mem_we    = draw_gnt && !draw_oob;
   assign mem_wdata = draw_wdata;
   assign mem_addr  = disp_gnt ? {front_sel, disp_addr} : draw_gnt ? {~front_sel, draw_addr} : '0;
   assign oob_err   = (disp_gnt && disp_oob) || (draw_gnt && draw_oob);
   assign disp_rdata   = (disp_rvalid && !rd_oob) ? mem_rdata : '0;
   assign swap_pending = state == PEND;
   always_comb begin
      toggle    = frame_done && (state == PEND || swap_req);
      state_nxt = state;
      if (state == IDLE && swap_req && !frame_done) state_nxt = PEND;
      if (state == PEND && frame_done) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         front_sel   <= 1'b0;
         swap_done   <= 1'b0;
         disp_rvalid <= 1'b0;
         rd_oob      <= 1'b0;
         starve_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         front_sel   <= front_sel ^ toggle;
         swap_done   <= toggle;
         disp_rvalid <= disp_gnt;
         rd_oob      <= disp_gnt && disp_oob;
         starve_cnt  <= (!draw_we || draw_gnt) ? '0 : (starve_cnt == SMAX) ? SMAX : starve_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector table plus hand sequences for starvation, swaps and reset
module tb_frame_buffer_arbiter;
   logic clk = 0, rst_n = 0;
   logic disp_re = 0, draw_we = 0, swap_req = 0, frame_done = 0;
   logic [16:0] disp_addr = 0, draw_addr = 0;
   logic [23:0] draw_wdata = 0, mem_rdata = 0;
   logic disp_gnt, disp_rvalid, draw_gnt, front_sel, swap_pending, swap_done, oob_err, mem_re, mem_we;
   logic [23:0] disp_rdata, mem_wdata;
   logic [17:0] mem_addr;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   frame_buffer_arbiter dut (
      .clk(clk), .rst_n(rst_n), .disp_re(disp_re), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .draw_we(draw_we), .draw_addr(draw_addr),
      .draw_wdata(draw_wdata), .draw_gnt(draw_gnt), .swap_req(swap_req), .frame_done(frame_done),
      .front_sel(front_sel), .swap_pending(swap_pending), .swap_done(swap_done), .oob_err(oob_err),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   typedef struct {
      logic dre; logic [16:0] da; logic dwe; logic [16:0] wa; logic [23:0] wd; logic [23:0] rd;
      logic egd, egw, ere, ewe, eoob, erv; logic [17:0] ema; logic [23:0] erd;
   } vec_t;
   vec_t v[9];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   initial begin
      v[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 18'h00000, 0};
      v[1] = '{1, 5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 18'h00005, 0};
      v[2] = '{0, 0, 1, 17'h10, 24'h123456, 24'hABCDEF, 0, 1, 0, 1, 0, 1, 18'h20010, 24'hABCDEF};
      v[3] = '{1, 7, 1, 9, 24'h777777, 0, 1, 0, 1, 0, 0, 0, 18'h00007, 0};
      v[4] = '{0, 0, 1, 76800, 24'h0F0F0F, 24'h111111, 0, 1, 0, 0, 1, 1, 18'h32C00, 24'h111111};
      v[5] = '{1, 76799, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 18'h12BFF, 0};
      v[6] = '{0, 0, 1, 76799, 24'hC0FFEE, 24'h222222, 0, 1, 0, 1, 0, 1, 18'h32BFF, 24'h222222};
      v[7] = '{1, 17'h1FFFF, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 18'h1FFFF, 0};
      v[8] = '{0, 0, 0, 0, 0, 24'h555555, 0, 0, 0, 0, 0, 1, 18'h00000, 0};
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk); #1;
      chk("rst front_sel", front_sel, 0);
      chk("rst swap_pending", swap_pending, 0);
      chk("rst mem_re", mem_re, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst swap_done", swap_done, 0);
      chk("rst rvalid", disp_rvalid, 0);
      chk("rst oob", oob_err, 0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         disp_re = v[i].dre; disp_addr = v[i].da; draw_we = v[i].dwe;
         draw_addr = v[i].wa; draw_wdata = v[i].wd; mem_rdata = v[i].rd;
         #1;
         chk($sformatf("v%0d disp_gnt", i), disp_gnt, v[i].egd);
         chk($sformatf("v%0d draw_gnt", i), draw_gnt, v[i].egw);
         chk($sformatf("v%0d mem_re", i), mem_re, v[i].ere);
         chk($sformatf("v%0d mem_we", i), mem_we, v[i].ewe);
         chk($sformatf("v%0d oob", i), oob_err, v[i].eoob);
         chk($sformatf("v%0d rvalid", i), disp_rvalid, v[i].erv);
         chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].ema);
         if (v[i].erv) chk($sformatf("v%0d rdata", i), disp_rdata, v[i].erd);
         if (v[i].ewe) chk($sformatf("v%0d wdata", i), mem_wdata, v[i].wd);
      end
      @(negedge clk);
      disp_re = 1; draw_we = 1; disp_addr = 2; draw_addr = 6; draw_wdata = 24'hAA55AA;
      for (int c = 1; c <= 10; c++) begin
         #1;
         chk($sformatf("starve c%0d disp_gnt", c), disp_gnt, c != 9);
         chk($sformatf("starve c%0d draw_gnt", c), draw_gnt, c == 9);
         chk($sformatf("starve c%0d mem_we", c), mem_we, c == 9);
         chk($sformatf("starve c%0d mem_addr", c), mem_addr, c == 9 ? 18'h20006 : 18'h00002);
         @(negedge clk);
      end
      disp_re = 0; draw_we = 0;
      @(negedge clk); swap_req = 1; #1;
      chk("swap pend early", swap_pending, 0);
      @(negedge clk); swap_req = 0; #1;
      chk("swap pend set", swap_pending, 1);
      repeat (98) begin
         @(negedge clk); #1;
         chk("swap pend hold", swap_pending, 1);
         chk("swap front hold", front_sel, 0);
      end
      @(negedge clk); frame_done = 1; disp_re = 1; disp_addr = 3; #1;
      chk("fd old map", mem_addr, 18'h00003);
      chk("fd front", front_sel, 0);
      @(negedge clk); frame_done = 0; #1;
      chk("post fd front", front_sel, 1);
      chk("post fd pend", swap_pending, 0);
      chk("post fd swap_done", swap_done, 1);
      chk("post fd disp map", mem_addr, 18'h20003);
      chk("post fd rvalid", disp_rvalid, 1);
      @(negedge clk); disp_re = 0; draw_we = 1; draw_addr = 4; #1;
      chk("draw new map", mem_addr, 18'h00004);
      chk("draw new we", mem_we, 1);
      chk("swap_done once", swap_done, 0);
      @(negedge clk); draw_we = 0; swap_req = 1; frame_done = 1; #1;
      chk("imm pend", swap_pending, 0);
      @(negedge clk); swap_req = 0; frame_done = 0; #1;
      chk("imm front", front_sel, 0);
      chk("imm pend after", swap_pending, 0);
      chk("imm swap_done", swap_done, 1);
      @(negedge clk); swap_req = 1;
      @(negedge clk); swap_req = 0; #1;
      chk("dbl pend", swap_pending, 1);
      @(negedge clk); swap_req = 1;
      @(negedge clk); swap_req = 0; #1;
      chk("dbl pend2", swap_pending, 1);
      chk("dbl front0", front_sel, 0);
      @(negedge clk); frame_done = 1;
      @(negedge clk); frame_done = 0; #1;
      chk("dbl front1", front_sel, 1);
      chk("dbl pend clr", swap_pending, 0);
      @(negedge clk); #1;
      chk("dbl no repend", swap_pending, 0);
      chk("dbl front stays", front_sel, 1);
      @(negedge clk); swap_req = 1;
      @(negedge clk); swap_req = 0; disp_re = 1; disp_addr = 1; #1;
      chk("rst pend before", swap_pending, 1);
      @(negedge clk); disp_re = 0; #1;
      chk("rst rvalid before", disp_rvalid, 1);
      #1 rst_n = 0; #1;
      chk("midrst pend", swap_pending, 0);
      chk("midrst front", front_sel, 0);
      chk("midrst rvalid", disp_rvalid, 0);
      @(negedge clk); rst_n = 1;
      @(negedge clk); #1;
      chk("after rst pend", swap_pending, 0);
      chk("after rst front", front_sel, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
